// File: rtl/riscv_core_mem_arbiter_if.sv
// Cache-side and memory-side signal bundle for the memory port arbiter.
// master: the arbiter's view. slave: the caches/AXI bridge view.
interface riscv_core_mem_arbiter_if #(
  parameter int unsigned ADDR_WIDTH      = 64,
  parameter int unsigned CORE_DATA_WIDTH = 64,
  parameter int unsigned AXI_DATA_WIDTH  = 256
);
  localparam int unsigned STRB_WIDTH = 8;

  // icache refill path
  logic                       i_ic_read_req;
  logic [ADDR_WIDTH-1:0]      i_ic_read_address;
  logic                       o_ic_read_done;
  logic [AXI_DATA_WIDTH-1:0]  o_ic_block;

  // dcache refill path
  logic                       i_dc_read_req;
  logic [ADDR_WIDTH-1:0]      i_dc_read_address;
  logic                       o_dc_read_done;
  logic [AXI_DATA_WIDTH-1:0]  o_dc_block;

  // dcache write-through store path
  logic                       i_dc_write_valid;
  logic [ADDR_WIDTH-1:0]      i_dc_write_address;
  logic [CORE_DATA_WIDTH-1:0] i_dc_write_data;
  logic [STRB_WIDTH-1:0]      i_dc_write_strobe;
  logic                       o_dc_write_done;

  // AXI bridge side
  logic                       o_mem_read_req;
  logic [ADDR_WIDTH-1:0]      o_mem_read_address;
  logic                       i_mem_read_done;
  logic [AXI_DATA_WIDTH-1:0]  i_mem_block;
  logic                       o_mem_write_valid;
  logic [ADDR_WIDTH-1:0]      o_mem_write_address;
  logic [CORE_DATA_WIDTH-1:0] o_mem_write_data;
  logic [STRB_WIDTH-1:0]      o_mem_write_strobe;
  logic                       i_mem_write_done;

  modport master (
    input  i_ic_read_req, i_ic_read_address,
    output o_ic_read_done, o_ic_block,
    input  i_dc_read_req, i_dc_read_address,
    output o_dc_read_done, o_dc_block,
    input  i_dc_write_valid, i_dc_write_address, i_dc_write_data, i_dc_write_strobe,
    output o_dc_write_done,
    output o_mem_read_req, o_mem_read_address,
    input  i_mem_read_done, i_mem_block,
    output o_mem_write_valid, o_mem_write_address, o_mem_write_data, o_mem_write_strobe,
    input  i_mem_write_done
  );

  modport slave (
    output i_ic_read_req, i_ic_read_address,
    input  o_ic_read_done, o_ic_block,
    output i_dc_read_req, i_dc_read_address,
    input  o_dc_read_done, o_dc_block,
    output i_dc_write_valid, i_dc_write_address, i_dc_write_data, i_dc_write_strobe,
    input  o_dc_write_done,
    input  o_mem_read_req, o_mem_read_address,
    output i_mem_read_done, i_mem_block,
    input  o_mem_write_valid, o_mem_write_address, o_mem_write_data, o_mem_write_strobe,
    output i_mem_write_done
  );
endinterface

// File: rtl/riscv_core_mem_arbiter.sv
// Shares one AXI memory port between icache refills, dcache refills and
// dcache write-through stores. One transaction in flight; stores win,
// refills alternate, and a burst limiter bounds how long a refill waits.
module riscv_core_mem_arbiter #(
  parameter int unsigned ADDR_WIDTH      = 64,
  parameter int unsigned CORE_DATA_WIDTH = 64,
  parameter int unsigned AXI_DATA_WIDTH  = 256,
  parameter int unsigned WRITE_BURST_MAX = 4
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  riscv_core_mem_arbiter_if.master  bus
);

  localparam int unsigned STRB_WIDTH = 8;
  localparam int unsigned CNT_W      = 4;
  localparam logic [CNT_W-1:0] CNT_SAT   = '1;
  localparam logic [CNT_W-1:0] BURST_LIM = CNT_W'(WRITE_BURST_MAX);
  localparam logic LAST_IC = 1'b0;
  localparam logic LAST_DC = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WRITE   = 3'd1,
    S_READ_IC = 3'd2,
    S_READ_DC = 3'd3,
    S_GAP     = 3'd4
  } state_t;

  state_t                     r_state;
  state_t                     w_state_nxt;
  logic [CNT_W-1:0]           r_burst_cnt;
  logic [CNT_W-1:0]           w_burst_cnt_nxt;
  logic                       r_last_read;
  logic                       w_last_read_nxt;

  logic                       w_rd_pend;
  logic                       w_grant_wr;
  logic                       w_grant_ic;
  logic                       w_grant_dc;
  logic                       w_wr_done;
  logic                       w_ic_done;
  logic                       w_dc_done;

  logic                       r_mem_read_req;
  logic [ADDR_WIDTH-1:0]      r_mem_read_address;
  logic                       r_mem_write_valid;
  logic [ADDR_WIDTH-1:0]      r_mem_write_address;
  logic [CORE_DATA_WIDTH-1:0] r_mem_write_data;
  logic [STRB_WIDTH-1:0]      r_mem_write_strobe;
  logic [AXI_DATA_WIDTH-1:0]  r_ic_block;
  logic [AXI_DATA_WIDTH-1:0]  r_dc_block;

  assign w_rd_pend = bus.i_ic_read_req | bus.i_dc_read_req;

  // State, round-robin pointer and burst counter registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_burst_cnt <= '0;
      r_last_read <= LAST_IC;
    end else begin
      r_state     <= w_state_nxt;
      r_burst_cnt <= w_burst_cnt_nxt;
      r_last_read <= w_last_read_nxt;
    end
  end

  // Arbitration, completion detection and next-state selection.
  always_comb begin
    w_state_nxt     = r_state;
    w_burst_cnt_nxt = r_burst_cnt;
    w_last_read_nxt = r_last_read;
    w_grant_wr      = 1'b0;
    w_grant_ic      = 1'b0;
    w_grant_dc      = 1'b0;
    w_wr_done       = 1'b0;
    w_ic_done       = 1'b0;
    w_dc_done       = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (bus.i_dc_write_valid && ((r_burst_cnt < BURST_LIM) || !w_rd_pend)) begin
          w_grant_wr      = 1'b1;
          w_state_nxt     = S_WRITE;
          w_burst_cnt_nxt = (r_burst_cnt == CNT_SAT) ? r_burst_cnt : r_burst_cnt + CNT_W'(1);
        end else if (w_rd_pend) begin
          // icache wins only when alone or when the dcache was served last
          if (bus.i_ic_read_req && (!bus.i_dc_read_req || (r_last_read == LAST_DC))) begin
            w_grant_ic  = 1'b1;
            w_state_nxt = S_READ_IC;
          end else begin
            w_grant_dc  = 1'b1;
            w_state_nxt = S_READ_DC;
          end
          w_burst_cnt_nxt = '0;
        end else begin
          w_burst_cnt_nxt = '0;
        end
      end
      S_WRITE: begin
        if (bus.i_mem_write_done && !i_rst) begin
          w_wr_done   = 1'b1;
          w_state_nxt = S_GAP;
        end
      end
      S_READ_IC: begin
        if (bus.i_mem_read_done && !i_rst) begin
          w_ic_done       = 1'b1;
          w_last_read_nxt = LAST_IC;
          w_state_nxt     = S_GAP;
        end
      end
      S_READ_DC: begin
        if (bus.i_mem_read_done && !i_rst) begin
          w_dc_done       = 1'b1;
          w_last_read_nxt = LAST_DC;
          w_state_nxt     = S_GAP;
        end
      end
      S_GAP: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Memory request registers: captured on grant, held until completion.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_mem_read_req      <= 1'b0;
      r_mem_read_address  <= '0;
      r_mem_write_valid   <= 1'b0;
      r_mem_write_address <= '0;
      r_mem_write_data    <= '0;
      r_mem_write_strobe  <= '0;
    end else begin
      if (w_grant_wr) begin
        r_mem_write_valid   <= 1'b1;
        r_mem_write_address <= bus.i_dc_write_address;
        r_mem_write_data    <= bus.i_dc_write_data;
        r_mem_write_strobe  <= bus.i_dc_write_strobe;
      end else if (w_wr_done) begin
        r_mem_write_valid   <= 1'b0;
      end
      if (w_grant_ic) begin
        r_mem_read_req     <= 1'b1;
        r_mem_read_address <= bus.i_ic_read_address;
      end else if (w_grant_dc) begin
        r_mem_read_req     <= 1'b1;
        r_mem_read_address <= bus.i_dc_read_address;
      end else if (w_ic_done || w_dc_done) begin
        r_mem_read_req     <= 1'b0;
      end
    end
  end

  // Refill block holding registers so each cache sees its last block.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ic_block <= '0;
      r_dc_block <= '0;
    end else begin
      if (w_ic_done) r_ic_block <= bus.i_mem_block;
      if (w_dc_done) r_dc_block <= bus.i_mem_block;
    end
  end

  assign bus.o_mem_read_req      = r_mem_read_req;
  assign bus.o_mem_read_address  = r_mem_read_address;
  assign bus.o_mem_write_valid   = r_mem_write_valid;
  assign bus.o_mem_write_address = r_mem_write_address;
  assign bus.o_mem_write_data    = r_mem_write_data;
  assign bus.o_mem_write_strobe  = r_mem_write_strobe;

  // Completion pulses and refill data pass straight through in the done cycle.
  assign bus.o_dc_write_done = w_wr_done;
  assign bus.o_ic_read_done  = w_ic_done;
  assign bus.o_dc_read_done  = w_dc_done;
  assign bus.o_ic_block      = w_ic_done ? bus.i_mem_block : r_ic_block;
  assign bus.o_dc_block      = w_dc_done ? bus.i_mem_block : r_dc_block;

endmodule
